// File: rtl/lsu_axi_master.sv
// lsu_axi_master: load/store unit bus front-end.
// Accepts one memory request at a time from the MEM stage, issues a single AXI-lite read or
// write into the data SRAM slave, and returns aligned, sign/zero-extended load data or a store
// completion with an error flag.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   req_*                 MEM-stage request: valid/ready, wen, byte addr, right-aligned wdata,
//                         size (00 byte, 01 half, 10 word, 11 illegal), unsigned-load flag
//   rsp_*                 response: valid/ready, extended load data, error flag
//   ar*/r*                AXI-lite read address / read data channels
//   aw*/w*/b*             AXI-lite write address / write data / write response channels
// All outputs come straight from flops.
module lsu_axi_master #(
  parameter int unsigned ADDR_W          = 32,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e state_q, state_d;

  // Latched request attributes needed to extract load data
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;

  // Accept-time decode of the incoming request
  logic              misalign;
  logic              acc_err;
  logic [1:0]        acc_off;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wstrb;
  logic [ADDR_W-1:0] bus_addr;

  // Load data extraction from the R beat
  logic [31:0]       ld_shift;
  logic [31:0]       ld_data;

  always_comb begin
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    acc_err  = (req_size == 2'b11) || (ERR_ON_MISALIGN && misalign);
    bus_addr = {req_addr[ADDR_W-1:2], 2'b00};

    // Offset within the word after force-aligning; misaligned requests only reach the bus
    // when ERR_ON_MISALIGN is clear.
    case (req_size)
      2'b00: begin
        acc_off   = req_addr[1:0];
        acc_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        acc_off   = {req_addr[1], 1'b0};
        acc_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        acc_off   = 2'b00;
        acc_wdata = req_wdata;
      end
    endcase

    case (req_size)
      2'b00:   acc_wstrb = 4'b0001 << acc_off;
      2'b01:   acc_wstrb = 4'b0011 << acc_off;
      default: acc_wstrb = 4'b1111;
    endcase
  end

  always_comb begin
    ld_shift = rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'b0, ld_shift[7:0]} : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = uns_q ? {16'b0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;

    unique case (state_q)
      StIdle: begin
        // req_ready_q is high throughout StIdle, so req_valid alone means accept
        if (req_valid) begin
          off_d       = acc_off;
          size_d      = req_size;
          uns_d       = req_unsigned;
          req_ready_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          if (acc_err) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_wen) begin
            state_d   = StWr;
            awaddr_d  = bus_addr;
            awvalid_d = 1'b1;
            wdata_d   = acc_wdata;
            wstrb_d   = acc_wstrb;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
          end else begin
            state_d   = StRd;
            araddr_d  = bus_addr;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end
        end
      end
      StRd: begin
        if (arvalid_q && arready) arvalid_d = 1'b0;
        if (rready_q && rvalid) begin
          rready_d = 1'b0;
          if (rresp != 2'b00) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            rsp_rdata_d = ld_data;
          end
        end
        if (!arvalid_d && !rready_d) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end
      end
      StWr: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (bready_q && bvalid) begin
          bready_d  = 1'b0;
          rsp_err_d = (bresp != 2'b00);
        end
        if (!awvalid_d && !wvalid_d && !bready_d) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;

endmodule
